// File: rtl/simon_pipe_stream_ctrl.sv
// -----------------------------------------------------------------------------
// simon_pipe_stream_ctrl
//
// Streams blocks from a plaintext BRAM through a fixed-latency, fully
// pipelined block-cipher core into a ciphertext BRAM. One block is issued per
// cycle. An address/valid shift register follows each block through the core,
// so the controller never stalls. The controller does not need to know the
// core's internal structure.
//
// Parameters
//   ADDR_W    BRAM byte-address width
//   NBLK_W    width of the block-count input
//   PIPE_LAT  cycles from core_load to valid core_ciphertext (1..32)
//
// Ports
//   clk, rst             single clock; asynchronous active-high reset
//   ctrl_in_begin        start request (only looked at while idle)
//   ctrl_in_num_blocks   number of 32-bit blocks, captured at start
//   ctrl_in_base_addr    byte address of the first block, captured at start
//   ctrl_in_abort        stop issuing new blocks; in-flight blocks still land
//   ctrl_in_key          64-bit key, forwarded unchanged to the core
//   pt_addra/pt_rd_data  plaintext BRAM read port (1-cycle read latency)
//   ct_addra/ct_wr_data/ct_wea  ciphertext BRAM write port
//   core_load/core_plaintext/core_key/core_ciphertext  cipher core interface
//   busy                 high while issuing or draining
//   done_intr            one-cycle completion pulse
//   aborted              sticky until the next start; the run was cut short
//   perf_cycles          (only with SIMON_STREAM_PERF_CNT_EN) busy-cycle
//                        count of the last run, saturating
//
// Optional feature macro: SIMON_STREAM_PERF_CNT_EN
// -----------------------------------------------------------------------------
module simon_pipe_stream_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int NBLK_W   = 11,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_in_begin,
  input  logic [NBLK_W-1:0] ctrl_in_num_blocks,
  input  logic [ADDR_W-1:0] ctrl_in_base_addr,
  input  logic              ctrl_in_abort,
  input  logic [63:0]       ctrl_in_key,
  output logic [ADDR_W-1:0] pt_addra,
  input  logic [31:0]       pt_rd_data,
  output logic [ADDR_W-1:0] ct_addra,
  output logic [31:0]       ct_wr_data,
  output logic [3:0]        ct_wea,
  output logic              core_load,
  output logic [31:0]       core_plaintext,
  output logic [63:0]       core_key,
  input  logic [31:0]       core_ciphertext,
  output logic              busy,
  output logic              done_intr,
  output logic              aborted
`ifdef SIMON_STREAM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [NBLK_W-1:0]   r_num;
  logic [NBLK_W-1:0]   r_issue_cnt;
  logic [ADDR_W-1:0]   r_pt_addr;
  logic                r_core_load;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;

  // Tag shift register: entry 0 lines up with core_load, entry PIPE_LAT with
  // the cycle the matching ciphertext appears on core_ciphertext.
  logic [PIPE_LAT:0]   r_sr_vld;
  logic [ADDR_W-1:0]   r_sr_addr [PIPE_LAT+1];

  logic                w_issue;
  logic [NBLK_W-1:0]   w_cnt_nxt;
  logic                w_inflight_after_shift;

  // A RUN cycle issues the block whose address is on pt_addra, unless abort
  // is asserted in that same cycle.
  assign w_issue   = (r_state == S_RUN) && !ctrl_in_abort;
  assign w_cnt_nxt = r_issue_cnt + NBLK_W'(1);

  // The entry in the last stage is written this cycle, so it does not keep
  // the pipe busy; only the younger entries matter for completion.
  assign w_inflight_after_shift = |r_sr_vld[PIPE_LAT-1:0];

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- control FSM: issue address, counters, status flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_issue_cnt <= '0;
      r_pt_addr   <= '0;
      r_core_load <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_core_load <= w_issue;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (ctrl_in_begin) begin
            r_num       <= ctrl_in_num_blocks;
            r_issue_cnt <= '0;
            r_pt_addr   <= ctrl_in_base_addr;
            r_aborted   <= 1'b0;
            if (ctrl_in_num_blocks == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ctrl_in_abort) begin
            r_state   <= S_DRAIN;
            r_aborted <= 1'b1;
          end else begin
            r_issue_cnt <= w_cnt_nxt;
            r_pt_addr   <= r_pt_addr + ADDR_W'(4);
            if (w_cnt_nxt == r_num) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (ctrl_in_abort && (r_issue_cnt != r_num)) begin
            r_aborted <= 1'b1;
          end
          if (!w_inflight_after_shift) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // ---- in-flight tag pipeline ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr_vld <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        r_sr_addr[i] <= '0;
      end
    end else begin
      r_sr_vld     <= {r_sr_vld[PIPE_LAT-1:0], w_issue};
      r_sr_addr[0] <= r_pt_addr;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        r_sr_addr[i] <= r_sr_addr[i-1];
      end
    end
  end

`ifdef SIMON_STREAM_PERF_CNT_EN
  logic [31:0] r_perf;

  // ---- busy-cycle counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && ctrl_in_begin) begin
      r_perf <= '0;
    end else if (r_busy) begin
      r_perf <= sat_inc32(r_perf);
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign pt_addra       = r_pt_addr;
  assign core_load      = r_core_load;
  assign core_plaintext = pt_rd_data;
  assign core_key       = ctrl_in_key;
  assign ct_addra       = r_sr_addr[PIPE_LAT];
  assign ct_wr_data     = core_ciphertext;
  assign ct_wea         = {4{r_sr_vld[PIPE_LAT]}};
  assign busy           = r_busy;
  assign done_intr      = r_done;
  assign aborted        = r_aborted;

endmodule

// File: tb/tb_simon_pipe_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for simon_pipe_stream_ctrl. Provides a plaintext BRAM whose
// contents are a fixed function of the address, and a stand-in cipher core
// with exactly PIPE_LAT cycles of latency. Each run's expected BRAM writes,
// loads, completion cycle and status flags are derived arithmetically from
// the block count, base address and abort cycle.
// -----------------------------------------------------------------------------
module tb_simon_pipe_stream_ctrl;

  localparam int L  = 3;
  localparam int AW = 32;
  localparam int NW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_begin;
  logic [NW-1:0] num;
  logic [AW-1:0] base_in;
  logic          abort;
  logic [63:0]   key;
  logic [AW-1:0] pt_addra;
  logic [31:0]   pt_rd_data;
  logic [AW-1:0] ct_addra;
  logic [31:0]   ct_wr_data;
  logic [3:0]    ct_wea;
  logic          core_load;
  logic [31:0]   core_plaintext;
  logic [63:0]   core_key;
  logic [31:0]   core_ciphertext;
  logic          busy;
  logic          done_intr;
  logic          aborted;
`ifdef SIMON_STREAM_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  simon_pipe_stream_ctrl #(.ADDR_W(AW), .NBLK_W(NW), .PIPE_LAT(L)) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_in_begin      (tb_begin),
    .ctrl_in_num_blocks (num),
    .ctrl_in_base_addr  (base_in),
    .ctrl_in_abort      (abort),
    .ctrl_in_key        (key),
    .pt_addra           (pt_addra),
    .pt_rd_data         (pt_rd_data),
    .ct_addra           (ct_addra),
    .ct_wr_data         (ct_wr_data),
    .ct_wea             (ct_wea),
    .core_load          (core_load),
    .core_plaintext     (core_plaintext),
    .core_key           (core_key),
    .core_ciphertext    (core_ciphertext),
    .busy               (busy),
    .done_intr          (done_intr),
    .aborted            (aborted)
`ifdef SIMON_STREAM_PERF_CNT_EN
    ,
    .perf_cycles        (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] salt = 32'h5A5A_1234;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    mem_f = (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [31:0] core_f(input logic [31:0] p, input logic [63:0] k);
    core_f = {p[18:0], p[31:19]} ^ k[31:0] ^ (k[63:32] + p);
  endfunction

  // Plaintext BRAM with one cycle of read latency.
  always @(posedge clk) pt_rd_data <= mem_f(pt_addra);

  // Stand-in core: result of the cycle's plaintext appears L cycles later.
  logic [31:0] cq [L];
  always @(posedge clk) begin
    cq[0] <= core_f(core_plaintext, core_key);
    for (int i = 1; i < L; i++) cq[i] <= cq[i-1];
  end
  assign core_ciphertext = cq[L-1];

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [31:0] pt;
  } ld_t;

  wr_t wq[$];
  ld_t lq[$];
  int  dq[$];
  int  busy_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (ct_wea != 4'h0) wq.push_back('{cyc, ct_addra, ct_wr_data, ct_wea});
      if (core_load)      lq.push_back('{cyc, core_plaintext});
      if (done_intr)      dq.push_back(cyc);
      if (busy)           busy_cnt++;
    end
  end

  int tests  = 0;
  int fails  = 0;
  int run_id = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s);
    tg = $sformatf("run%0d_%s", run_id, s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // abort_k: cycle (relative to the begin cycle 0) in which abort is pulsed;
  // 0 means no abort. noise: pulse begin again while the run is active.
  task automatic run(input logic [31:0] base, input int n, input int abort_k, input bit noise);
    int m, exp_done, exp_busy, k, t0;
    bit exp_ab;
    logic [31:0] a;
    run_id++;
    exp_ab = (abort_k >= 1) && (abort_k <= n);
    m      = exp_ab ? abort_k - 1 : n;
    if (n == 0)      exp_done = 1;
    else if (m == 0) exp_done = 3;
    else             exp_done = m + 2 + L;
    exp_busy = (n == 0) ? 0 : exp_done - 1;

    wq.delete(); lq.delete(); dq.delete(); busy_cnt = 0;
    key      = {$urandom, $urandom};
    num      = NW'(n);
    base_in  = base;
    tb_begin = 1'b1;
    t0       = cyc;
    step();
    tb_begin = 1'b0;
    k = 1;
    while (dq.size() == 0 && k < 300) begin
      abort    = (k == abort_k);
      tb_begin = noise && (k == 3);
      step();
      k++;
    end
    abort    = 1'b0;
    tb_begin = 1'b0;
    repeat (4) step();

    check(tg("done_count"), dq.size(), 1);
    if (dq.size() > 0) check(tg("done_cycle"), dq[0] - t0, exp_done);
    check(tg("write_count"), wq.size(), m);
    check(tg("load_count"), lq.size(), m);
    for (int i = 0; i < m && i < wq.size(); i++) begin
      a = base + 32'(4 * i);
      check(tg($sformatf("wr%0d_addr", i)), wq[i].addr, a);
      check(tg($sformatf("wr%0d_data", i)), wq[i].data, core_f(mem_f(a), key));
      check(tg($sformatf("wr%0d_we", i)), wq[i].we, 4'hF);
      check(tg($sformatf("wr%0d_cyc", i)), wq[i].cyc - t0, i + 2 + L);
    end
    for (int i = 0; i < m && i < lq.size(); i++) begin
      a = base + 32'(4 * i);
      check(tg($sformatf("ld%0d_pt", i)), lq[i].pt, mem_f(a));
      check(tg($sformatf("ld%0d_cyc", i)), lq[i].cyc - t0, i + 2);
    end
    check(tg("busy_cycles"), busy_cnt, exp_busy);
    check(tg("aborted"), aborted, exp_ab);
    check(tg("busy_idle"), busy, 1'b0);
`ifdef SIMON_STREAM_PERF_CNT_EN
    check(tg("perf_cycles"), perf_cycles, exp_busy);
`endif
  endtask

  initial begin
    int n, ak;
    rst = 1'b1; tb_begin = 1'b0; num = '0; base_in = '0; abort = 1'b0; key = '0;
    salt = $urandom;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_intr, 1'b0);
    check("rst_aborted", aborted, 1'b0);
    check("rst_load", core_load, 1'b0);
    check("rst_wea", ct_wea, 4'h0);
    check("rst_pt_addr", pt_addra, 32'h0);
    check("rst_ct_addr", ct_addra, 32'h0);
    rst = 1'b0;
    step();

    run(32'h0000_0100, 4, 0, 1'b0);
    run(32'h0000_0200, 0, 0, 1'b0);
    run(32'h0000_0300, 0, 1, 1'b0);
    run(32'h0000_1000, 10, 4, 1'b0);
    run(32'hFFFF_FFF8, 4, 0, 1'b0);
    run(32'h0000_2000, 5, 1, 1'b0);
    run(32'h0000_3000, 2, 3, 1'b0);
    run(32'h0000_4000, 6, 0, 1'b1);

    // Asynchronous reset in the middle of a run.
    wq.delete(); lq.delete(); dq.delete();
    num = NW'(10); base_in = 32'h0000_8000; tb_begin = 1'b1;
    step();
    tb_begin = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_load", core_load, 1'b0);
    check("mid_rst_wea", ct_wea, 4'h0);
    check("mid_rst_pt_addr", pt_addra, 32'h0);
    check("mid_rst_ct_addr", ct_addra, 32'h0);
    check("mid_rst_done", done_intr, 1'b0);
    wq.delete(); lq.delete(); dq.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    check("post_rst_writes", wq.size(), 0);
    check("post_rst_loads", lq.size(), 0);
    check("post_rst_done", dq.size(), 0);
    run(32'h0000_9000, 3, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(1, 12);
      ak = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + 3) : 0;
      run($urandom, n, ak, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
